// File: rtl/lcd_panel_rx_pkg.sv
// Shared definitions for the LCD panel serial receiver.
// Holds the panel command opcodes, the command decoder state type and the
// pixel width. There are no ports.
package lcd_panel_rx_pkg;

  localparam logic [7:0] OP_SLPOUT = 8'h11;
  localparam logic [7:0] OP_CASET  = 8'h2A;
  localparam logic [7:0] OP_PASET  = 8'h2B;
  localparam logic [7:0] OP_RAMWR  = 8'h2C;

  localparam int RGB565_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CASET = 2'd1,
    ST_PASET = 2'd2,
    ST_RAMWR = 2'd3
  } dec_state_e;

endpackage

// File: rtl/lcd_byte_rx.sv
// Byte assembler for the LCD serial bus.
// Synchronises sda/scl/cs/rs, shifts sda MSB-first on each rising scl while
// cs is low, and emits one byte per 8 bits. Dropping cs mid-byte throws the
// partial byte away.
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   sda_i/scl_i/cs_i/rs_i raw bus inputs (cs active-low)
//   byte_valid_o          single-cycle strobe, one per completed byte
//   byte_o, byte_rs_o     byte value and rs level latched on the 8th edge
// Handshake: byte_valid_o is a one-cycle strobe with no back-pressure; the
// consumer must take byte_o/byte_rs_o in the cycle the strobe is high.
module lcd_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sda_i,
  input  logic       scl_i,
  input  logic       cs_i,
  input  logic       rs_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       byte_rs_o
);

  logic [SYNC_STAGES-1:0] sda_sync_q, scl_sync_q, cs_sync_q, rs_sync_q;
  logic                   sda_s, scl_s, cs_s, rs_s;
  logic                   scl_prev_q;
  logic [6:0]             shift_q, shift_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic                   valid_q, valid_d;
  logic [7:0]             byte_q, byte_d;
  logic                   rs_q, rs_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sda_sync_q <= '0;
      scl_sync_q <= '0;
      cs_sync_q  <= '1;   // bus idles deselected
      rs_sync_q  <= '0;
    end else begin
      sda_sync_q[0] <= sda_i;
      scl_sync_q[0] <= scl_i;
      cs_sync_q[0]  <= cs_i;
      rs_sync_q[0]  <= rs_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sda_sync_q[i] <= sda_sync_q[i-1];
        scl_sync_q[i] <= scl_sync_q[i-1];
        cs_sync_q[i]  <= cs_sync_q[i-1];
        rs_sync_q[i]  <= rs_sync_q[i-1];
      end
    end
  end

  assign sda_s = sda_sync_q[SYNC_STAGES-1];
  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign cs_s  = cs_sync_q[SYNC_STAGES-1];
  assign rs_s  = rs_sync_q[SYNC_STAGES-1];

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    valid_d   = 1'b0;
    byte_d    = byte_q;
    rs_d      = rs_q;
    if (cs_s) begin
      bit_cnt_d = 3'd0;
    end else if (scl_s && !scl_prev_q) begin
      if (bit_cnt_q == 3'd7) begin
        byte_d    = {shift_q, sda_s};
        rs_d      = rs_s;
        valid_d   = 1'b1;
        bit_cnt_d = 3'd0;
      end else begin
        shift_d   = {shift_q[5:0], sda_s};
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_prev_q <= 1'b0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      valid_q    <= 1'b0;
      byte_q     <= '0;
      rs_q       <= 1'b0;
    end else begin
      scl_prev_q <= scl_s;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      valid_q    <= valid_d;
      byte_q     <= byte_d;
      rs_q       <= rs_d;
    end
  end

  assign byte_valid_o = valid_q;
  assign byte_o       = byte_q;
  assign byte_rs_o    = rs_q;

endmodule

// File: rtl/lcd_panel_rx.sv
// LCD panel serial receiver: decodes the command/data byte stream of a
// serial LCD controller and turns RAMWR data into addressed RGB565 pixels.
// Ports:
//   clk, reset                  system clock, asynchronous active-high reset
//   sda, scl, cs, rs            serial bus (cs active-low, rs 0=cmd 1=data)
//   pix_valid/pix_data          one-cycle pixel strobe and RGB565 value
//   pix_x/pix_y                 pixel coordinates (held between strobes)
//   frame_start/frame_done      strobes on RAMWR and on the window's last pixel
//   awake                       set by SLPOUT
//   cmd_valid/cmd_byte          strobe and value for every command byte
//   dbg_state_o                 current decoder state
module lcd_panel_rx
  import lcd_panel_rx_pkg::*;
#(
  parameter int WIDTH       = 320,
  parameter int HEIGHT      = 240,
  parameter int SYNC_STAGES = 2,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sda,
  input  logic                scl,
  input  logic                cs,
  input  logic                rs,
  output logic                pix_valid,
  output logic [RGB565_W-1:0] pix_data,
  output logic [XW-1:0]       pix_x,
  output logic [YW-1:0]       pix_y,
  output logic                frame_start,
  output logic                frame_done,
  output logic                awake,
  output logic                cmd_valid,
  output logic [7:0]          cmd_byte,
  output dec_state_e          dbg_state_o
);

  localparam logic [15:0]   X_MAX  = 16'(WIDTH - 1);
  localparam logic [15:0]   Y_MAX  = 16'(HEIGHT - 1);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  logic       rx_valid, rx_rs;
  logic [7:0] rx_byte;

  lcd_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_byte_rx (
    .clk          (clk),
    .reset        (reset),
    .sda_i        (sda),
    .scl_i        (scl),
    .cs_i         (cs),
    .rs_i         (rs),
    .byte_valid_o (rx_valid),
    .byte_o       (rx_byte),
    .byte_rs_o    (rx_rs)
  );

  dec_state_e          state_q, state_d;
  logic [XW-1:0]       col_start_q, col_start_d, col_end_q, col_end_d;
  logic [YW-1:0]       page_start_q, page_start_d, page_end_q, page_end_d;
  logic [23:0]         param_q, param_d;      // first three CASET/PASET bytes
  logic [1:0]          pcnt_q, pcnt_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [7:0]          hi_q, hi_d;
  logic                low_phase_q, low_phase_d;  // high byte already held
  logic                pix_valid_q, pix_valid_d;
  logic [RGB565_W-1:0] pix_data_q, pix_data_d;
  logic [XW-1:0]       pix_x_q, pix_x_d;
  logic [YW-1:0]       pix_y_q, pix_y_d;
  logic                fstart_q, fstart_d, fdone_q, fdone_d;
  logic                awake_q, awake_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic [7:0]          cmd_byte_q, cmd_byte_d;

  // Range commit for the 4th parameter byte: end is clamped to the panel
  // edge first, then start is clamped to end.
  logic [15:0] p_start, p_end, p_lim, end_c, start_c;
  assign p_start = param_q[23:8];
  assign p_end   = {param_q[7:0], rx_byte};
  assign p_lim   = (state_q == ST_CASET) ? X_MAX : Y_MAX;
  assign end_c   = (p_end > p_lim) ? p_lim : p_end;
  assign start_c = (p_start > end_c) ? end_c : p_start;

  always_comb begin
    state_d      = state_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    param_d      = param_q;
    pcnt_d       = pcnt_q;
    x_d          = x_q;
    y_d          = y_q;
    hi_d         = hi_q;
    low_phase_d  = low_phase_q;
    pix_valid_d  = 1'b0;
    pix_data_d   = pix_data_q;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    fstart_d     = 1'b0;
    fdone_d      = 1'b0;
    awake_d      = awake_q;
    cmd_valid_d  = 1'b0;
    cmd_byte_d   = cmd_byte_q;

    if (rx_valid && !rx_rs) begin
      // Any command aborts pending parameters and a dangling high byte.
      cmd_valid_d = 1'b1;
      cmd_byte_d  = rx_byte;
      pcnt_d      = 2'd0;
      low_phase_d = 1'b0;
      case (rx_byte)
        OP_SLPOUT: begin awake_d = 1'b1; state_d = ST_IDLE; end
        OP_CASET:  state_d = ST_CASET;
        OP_PASET:  state_d = ST_PASET;
        OP_RAMWR: begin
          state_d  = ST_RAMWR;
          x_d      = col_start_q;
          y_d      = page_start_q;
          fstart_d = 1'b1;
        end
        default:   state_d = ST_IDLE;
      endcase
    end else if (rx_valid) begin
      case (state_q)
        ST_CASET, ST_PASET: begin
          if (pcnt_q == 2'd3) begin
            if (state_q == ST_CASET) begin
              col_start_d = start_c[XW-1:0];
              col_end_d   = end_c[XW-1:0];
            end else begin
              page_start_d = start_c[YW-1:0];
              page_end_d   = end_c[YW-1:0];
            end
            pcnt_d  = 2'd0;
            state_d = ST_IDLE;
          end else begin
            param_d = {param_q[15:0], rx_byte};
            pcnt_d  = pcnt_q + 2'd1;
          end
        end
        ST_RAMWR: begin
          if (!low_phase_q) begin
            hi_d        = rx_byte;
            low_phase_d = 1'b1;
          end else begin
            low_phase_d = 1'b0;
            pix_valid_d = 1'b1;
            pix_data_d  = {hi_q, rx_byte};
            pix_x_d     = x_q;
            pix_y_d     = y_q;
            if (x_q == col_end_q) begin
              x_d = col_start_q;
              if (y_q == page_end_q) begin
                y_d     = page_start_q;
                fdone_d = 1'b1;
              end else begin
                y_d = y_q + 1'b1;
              end
            end else begin
              x_d = x_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      col_start_q  <= '0;
      col_end_q    <= X_LAST;
      page_start_q <= '0;
      page_end_q   <= Y_LAST;
      param_q      <= '0;
      pcnt_q       <= '0;
      x_q          <= '0;
      y_q          <= '0;
      hi_q         <= '0;
      low_phase_q  <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= '0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      fstart_q     <= 1'b0;
      fdone_q      <= 1'b0;
      awake_q      <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_byte_q   <= '0;
    end else begin
      state_q      <= state_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
      param_q      <= param_d;
      pcnt_q       <= pcnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      hi_q         <= hi_d;
      low_phase_q  <= low_phase_d;
      pix_valid_q  <= pix_valid_d;
      pix_data_q   <= pix_data_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      fstart_q     <= fstart_d;
      fdone_q      <= fdone_d;
      awake_q      <= awake_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_byte_q   <= cmd_byte_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_data    = pix_data_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign frame_start = fstart_q;
  assign frame_done  = fdone_q;
  assign awake       = awake_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_byte    = cmd_byte_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lcd_panel_rx.sv
// Testbench for lcd_panel_rx on a reduced 16x12 panel so a full frame fits
// in a short run.
module tb_lcd_panel_rx;

  localparam int TW = 16;
  localparam int TH = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic sda = 1'b0, scl = 1'b0, cs = 1'b1, rs = 1'b0;
  logic        pix_valid, frame_start, frame_done, awake, cmd_valid;
  logic [15:0] pix_data;
  logic [3:0]  pix_x, pix_y;
  logic [7:0]  cmd_byte;
  logic [1:0]  dbg_state;

  lcd_panel_rx #(.WIDTH(TW), .HEIGHT(TH), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sda(sda), .scl(scl), .cs(cs), .rs(rs),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .frame_start(frame_start), .frame_done(frame_done), .awake(awake),
    .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_fail = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  typedef struct {
    logic [15:0] d;
    int          x;
    int          y;
    bit          fd;
  } pix_t;

  logic [7:0] exp_q[$];      // expected command bytes
  pix_t       exp_pix_q[$];  // expected pixels
  int         exp_fs = 0;    // expected frame_start strobes outstanding
  int         fs_seen = 0, fd_seen = 0;
  logic [15:0] last_d = '0;
  int          last_x = 0, last_y = 0;

  // ---------------- behavioural model (byte level) ----------------
  int  m_state;  // 0 idle, 1 column set, 2 page set, 3 memory write
  int  m_cs, m_ce, m_ps, m_pe, m_x, m_y, m_pn;
  bit  m_awake, m_have_hi;
  logic [7:0] m_p[4];
  logic [7:0] m_hi;

  function automatic void model_reset();
    m_state = 0; m_cs = 0; m_ce = TW - 1; m_ps = 0; m_pe = TH - 1;
    m_x = 0; m_y = 0; m_pn = 0; m_awake = 0; m_have_hi = 0; m_hi = '0;
    exp_q.delete(); exp_pix_q.delete(); exp_fs = 0;
    last_d = '0; last_x = 0; last_y = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b, input logic r);
    int s, e, mx;
    pix_t p;
    if (!r) begin
      exp_q.push_back(b);
      m_pn = 0; m_have_hi = 0;
      case (b)
        8'h11: begin m_awake = 1; m_state = 0; end
        8'h2A: m_state = 1;
        8'h2B: m_state = 2;
        8'h2C: begin m_state = 3; m_x = m_cs; m_y = m_ps; exp_fs++; end
        default: m_state = 0;
      endcase
    end else if (m_state == 1 || m_state == 2) begin
      m_p[m_pn] = b;
      m_pn++;
      if (m_pn == 4) begin
        s  = m_p[0] * 256 + m_p[1];
        e  = m_p[2] * 256 + m_p[3];
        mx = (m_state == 1) ? TW - 1 : TH - 1;
        if (e > mx) e = mx;
        if (s > e) s = e;
        if (m_state == 1) begin m_cs = s; m_ce = e; end
        else begin m_ps = s; m_pe = e; end
        m_state = 0; m_pn = 0;
      end
    end else if (m_state == 3) begin
      if (!m_have_hi) begin
        m_hi = b; m_have_hi = 1;
      end else begin
        m_have_hi = 0;
        p.d = {m_hi, b}; p.x = m_x; p.y = m_y;
        p.fd = (m_x == m_ce) && (m_y == m_pe);
        exp_pix_q.push_back(p);
        m_x++;
        if (m_x > m_ce) begin
          m_x = m_cs; m_y++;
          if (m_y > m_pe) m_y = m_ps;
        end
      end
    end
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (cmd_valid) begin
        if (exp_q.size() == 0) chk("cmd_unexpected", 32'(cmd_byte), 32'hFFFF_FFFF);
        else chk("cmd_byte", 32'(cmd_byte), 32'(exp_q.pop_front()));
      end
      if (frame_start) begin
        fs_seen++;
        if (exp_fs == 0) chk("frame_start_unexpected", 1, 0);
        else exp_fs--;
      end
      if (frame_done) fd_seen++;
      if (pix_valid) begin
        if (exp_pix_q.size() == 0) chk("pix_unexpected", 32'(pix_data), 32'hFFFF_FFFF);
        else begin
          pix_t p;
          p = exp_pix_q.pop_front();
          chk("pix_data", 32'(pix_data), 32'(p.d));
          chk("pix_x", 32'(pix_x), 32'(p.x));
          chk("pix_y", 32'(pix_y), 32'(p.y));
          chk("frame_done", 32'(frame_done), 32'(p.fd));
          last_d = p.d; last_x = p.x; last_y = p.y;
        end
      end else begin
        chk("frame_done_idle", 32'(frame_done), 0);
        chk("pix_hold", {8'h0, pix_x, pix_y, pix_data}, {8'h0, 4'(last_x), 4'(last_y), last_d});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; cs = 1'b1; scl = 1'b0; sda = 1'b0; rs = 1'b0;
    model_reset();
    tick(3);
    @(negedge clk);
    reset = 1'b0;
    tick(2);
  endtask

  // Sends the top n bits of b; the model sees only complete bytes.
  task automatic send_bits(input logic [7:0] b, input logic r, input int n, input bit to_model);
    cs = 1'b0; rs = r;
    for (int i = 7; i > 7 - n; i--) begin
      sda = b[i]; scl = 1'b0;
      tick(3);
      scl = 1'b1;
      if (i == 0 && to_model) model_byte(b, r);
      tick(3);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic r);
    send_bits(b, r, 8, 1'b1);
  endtask

  task automatic cs_release();
    scl = 1'b0; tick(3);
    cs = 1'b1; tick(6);
  endtask

  task automatic send_pixel(input logic [15:0] d);
    send_byte(d[15:8], 1'b1);
    send_byte(d[7:0], 1'b1);
  endtask

  task automatic send_window(input logic [7:0] op, input logic [15:0] s, input logic [15:0] e);
    send_byte(op, 1'b0);
    send_byte(s[15:8], 1'b1); send_byte(s[7:0], 1'b1);
    send_byte(e[15:8], 1'b1); send_byte(e[7:0], 1'b1);
  endtask

  // ---------------- stimulus ----------------
  int fd0;

  initial begin
    model_reset();
    do_reset();
    // reset state
    chk("rst_outputs", {pix_valid, frame_start, frame_done, awake, cmd_valid}, 0);
    chk("rst_values", {cmd_byte, pix_data, pix_x, pix_y}, 0);

    // sleep-out
    send_byte(8'h11, 1'b0); cs_release();
    chk("awake_lit", 32'(awake), 1);
    chk("awake_model", 32'(awake), 32'(m_awake));

    // RAMWR and two pixels in one cs-low period
    send_byte(8'h2C, 1'b0);
    send_pixel(16'hF800); send_pixel(16'h07E0); cs_release();
    chk("ramwr_last_data", 32'(pix_data), 32'h07E0);
    chk("ramwr_last_xy", {pix_x, pix_y}, {4'd1, 4'd0});
    chk("ramwr_fs_count", 32'(fs_seen), 1);

    // 2x2 window at (10..11, 5..6)
    send_window(8'h2A, 16'd10, 16'd11);
    send_window(8'h2B, 16'd5, 16'd6);
    send_byte(8'h2C, 1'b0);
    fd0 = fd_seen;
    send_pixel(16'h1111); send_pixel(16'h2222);
    send_pixel(16'h3333); send_pixel(16'h4444); cs_release();
    chk("win_fd_count", 32'(fd_seen - fd0), 1);
    chk("win_4th_xy", {pix_x, pix_y}, {4'd11, 4'd6});
    send_pixel(16'h5555); cs_release();
    chk("win_5th_xy", {pix_x, pix_y}, {4'd10, 4'd5});

    // aborted column set leaves the window alone
    send_byte(8'h2A, 1'b0); send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    send_byte(8'h2C, 1'b0); send_pixel(16'hA5A5); cs_release();
    chk("abort_xy", {pix_x, pix_y}, {4'd10, 4'd5});

    // clamping: start above end, end above panel
    send_window(8'h2A, 16'h0100, 16'd5);
    send_window(8'h2B, 16'd8, 16'hFFFF);
    send_byte(8'h2C, 1'b0);
    fd0 = fd_seen;
    for (int i = 0; i < 4; i++) send_pixel(16'(16'hC000 + i));
    cs_release();
    chk("clamp_xy", {pix_x, pix_y}, {4'd5, 4'd11});
    chk("clamp_fd", 32'(fd_seen - fd0), 1);

    // dangling high byte, ignored data in idle
    send_byte(8'h2C, 1'b0); send_byte(8'hEE, 1'b1);
    send_byte(8'h00, 1'b0); send_byte(8'h55, 1'b1);
    send_byte(8'h2C, 1'b0); send_pixel(16'hABCD); cs_release();
    chk("dangle_data", 32'(pix_data), 32'hABCD);

    // partial byte dropped by cs
    send_bits(8'hFF, 1'b0, 5, 1'b0); cs_release();
    send_byte(8'h2C, 1'b0); cs_release();
    chk("partial_state", 32'(dbg_state), 3);

    // full frame on default window
    do_reset();
    send_byte(8'h2C, 1'b0);
    fd0 = fd_seen;
    for (int i = 0; i < TW * TH; i++) send_pixel(16'(i * 257 + 3));
    cs_release();
    chk("frame_fd_count", 32'(fd_seen - fd0), 1);
    chk("frame_last_xy", {pix_x, pix_y}, {4'd15, 4'd11});
    send_pixel(16'h0BAD); cs_release();
    chk("frame_wrap_xy", {pix_x, pix_y}, {4'd0, 4'd0});

    // reset mid-pixel and mid-byte
    send_byte(8'h2C, 1'b0); send_byte(8'hAB, 1'b1);
    do_reset();
    send_bits(8'hFF, 1'b1, 3, 1'b0);
    do_reset();
    send_byte(8'h2C, 1'b0); send_pixel(16'h1234); cs_release();
    chk("rst_pix_data", 32'(pix_data), 32'h1234);
    chk("rst_pix_xy", {pix_x, pix_y}, {4'd0, 4'd0});
    chk("rst_awake", 32'(awake), 0);

    // drain
    for (int i = 0; i < 200 && (exp_q.size() + exp_pix_q.size() + exp_fs) != 0; i++) tick(1);
    chk("drain_cmd", 32'(exp_q.size()), 0);
    chk("drain_pix", 32'(exp_pix_q.size()), 0);
    chk("drain_fs", 32'(exp_fs), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
